// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: oversampled MDC/MDIO, 32x16 register file.
// Define MDIO_PRE_SUPPRESS_EN to allow preamble-less frames after a served frame.
module mdio_phy_responder #(
   parameter logic [15:0] PHY_ID1      = 16'h0022,
   parameter logic [15:0] PHY_ID2      = 16'h1622,
   parameter logic [15:0] BMCR_RST     = 16'h1140,
   parameter int          PREAMBLE_LEN = 32,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  phy_addr,
   input  logic [15:0] status,
   input  logic        mdc_i,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_t,
   output logic        wr_valid,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data
);

   localparam int PCW = $clog2(PREAMBLE_LEN + 1);
   localparam logic [PCW-1:0] PRE_FULL = PCW'(PREAMBLE_LEN);
   localparam logic [PCW-1:0] PRE_ONE  = PCW'(1);
`ifdef MDIO_PRE_SUPPRESS_EN
   localparam logic           PS_BIT  = 1'b1;
   localparam logic [PCW-1:0] PRE_END = PRE_FULL;
`else
   localparam logic           PS_BIT  = 1'b0;
   localparam logic [PCW-1:0] PRE_END = '0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
   } state_t;

   logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
   logic                   mdc_last_q;
   logic                   mdc_rise, mdio_s;

   state_t         state_q, state_d;
   logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [15:0]    shift_q, shift_d, shift_in;
   logic           is_rd_q, is_rd_d;
   logic [4:0]     regad_q, regad_d;
   logic [15:0]    rd_data_q, rd_data_d, rd_mux;
   logic           commit;

   logic        mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
   logic        wr_valid_q, wr_valid_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic [15:0] regs_q [32];

   // BMSR bit 6 is replaced by the preamble-suppression capability.
   logic unused_status_bit;
   assign unused_status_bit = status[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdc_sync_q  <= '0;
         mdio_sync_q <= '0;
         mdc_last_q  <= 1'b0;
      end else begin
         mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
         mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
         mdc_last_q  <= mdc_sync_q[SYNC_STAGES-1];
      end
   end

   assign mdc_rise = mdc_sync_q[SYNC_STAGES-1] & ~mdc_last_q;
   assign mdio_s   = mdio_sync_q[SYNC_STAGES-1];
   assign shift_in = {shift_q[14:0], mdio_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pre_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         is_rd_q    <= 1'b0;
         regad_q    <= '0;
         rd_data_q  <= '0;
         mdio_o_q   <= 1'b0;
         mdio_t_q   <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         is_rd_q    <= is_rd_d;
         regad_q    <= regad_d;
         rd_data_q  <= rd_data_d;
         mdio_o_q   <= mdio_o_d;
         mdio_t_q   <= mdio_t_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   always_comb begin
      rd_mux = regs_q[regad_q];
      case (regad_q)
         5'd1:    rd_mux = {status[15:7], PS_BIT, status[5:0]};
         5'd2:    rd_mux = PHY_ID1;
         5'd3:    rd_mux = PHY_ID2;
         default: rd_mux = regs_q[regad_q];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      is_rd_d   = is_rd_q;
      regad_d   = regad_q;
      rd_data_d = rd_data_q;
      commit    = 1'b0;
      if (mdc_rise) begin
         shift_d   = shift_in;
         bit_cnt_d = bit_cnt_q + 4'd1;
         case (state_q)
            S_IDLE: begin
               bit_cnt_d = '0;
               if (mdio_s) begin
                  if (pre_cnt_q < PRE_FULL) pre_cnt_d = pre_cnt_q + PRE_ONE;
               end else if (pre_cnt_q >= PRE_FULL) begin
                  state_d   = S_ST;
                  pre_cnt_d = '0;
               end else begin
                  pre_cnt_d = '0;
               end
            end
            S_ST: begin
               bit_cnt_d = '0;
               state_d   = mdio_s ? S_OP : S_IDLE;
            end
            S_OP: if (bit_cnt_q == 4'd1) begin
               bit_cnt_d = '0;
               is_rd_d   = (shift_in[1:0] == 2'b10);
               state_d   = (shift_in[1] ^ shift_in[0]) ? S_PHYAD : S_IDLE;
            end
            S_PHYAD: if (bit_cnt_q == 4'd4) begin
               bit_cnt_d = '0;
               state_d   = (shift_in[4:0] == phy_addr) ? S_REGAD : S_IDLE;
            end
            S_REGAD: if (bit_cnt_q == 4'd4) begin
               bit_cnt_d = '0;
               regad_d   = shift_in[4:0];
               state_d   = S_TA;
            end
            S_TA: if (bit_cnt_q == 4'd0) begin
               if (is_rd_q) rd_data_d = rd_mux;
            end else begin
               bit_cnt_d = '0;
               state_d   = S_DATA;
               if (is_rd_q) rd_data_d = {rd_data_q[14:0], 1'b0};
            end
            S_DATA: begin
               if (is_rd_q) rd_data_d = {rd_data_q[14:0], 1'b0};
               if (bit_cnt_q == 4'd15) begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
                  pre_cnt_d = PRE_END;
                  commit    = ~is_rd_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // rd_data_q[15] always holds the next bit to present on the pad.
   always_comb begin
      mdio_o_d   = mdio_o_q;
      mdio_t_d   = mdio_t_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (mdc_rise && is_rd_q) begin
         case (state_q)
            S_TA: begin
               if (bit_cnt_q == 4'd0) begin
                  mdio_t_d = 1'b0;
                  mdio_o_d = 1'b0;
               end else begin
                  mdio_o_d = rd_data_q[15];
               end
            end
            S_DATA: begin
               if (bit_cnt_q == 4'd15) begin
                  mdio_t_d = 1'b1;
                  mdio_o_d = 1'b0;
               end else begin
                  mdio_o_d = rd_data_q[15];
               end
            end
            default: ;
         endcase
      end
      if (commit) begin
         wr_valid_d = 1'b1;
         wr_addr_d  = regad_q;
         wr_data_d  = shift_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= (i == 0) ? BMCR_RST : 16'h0000;
      end else if (commit) begin
         if (regad_q == 5'd0)
            regs_q[0] <= shift_in[15] ? BMCR_RST : shift_in;
         else if (regad_q >= 5'd4)
            regs_q[regad_q] <= shift_in;
      end
   end

   assign mdio_o   = mdio_o_q;
   assign mdio_t   = mdio_t_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged Clause-22 frames with a pulled-up shared MDIO line.
module tb_mdio_phy_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  phy_addr = 5'd1;
   logic [15:0] status = 16'h7849;
   logic        mdc = 1'b0;
   logic        m_drv = 1'b1;
   logic        mdio_in;
   logic        mdio_o, mdio_t, wr_valid;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;

   int errors = 0;
   int checks = 0;
   int wr_pulses = 0;

`ifdef MDIO_PRE_SUPPRESS_EN
   localparam logic [15:0] BMSR_EXP = 16'h7849;
   localparam logic [15:0] B2B_DATA = 16'h7849;
   localparam int          B2B_TLOW = 17;
`else
   localparam logic [15:0] BMSR_EXP = 16'h7809;
   localparam logic [15:0] B2B_DATA = 16'hFFFF;
   localparam int          B2B_TLOW = 0;
`endif

   mdio_phy_responder dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .phy_addr (phy_addr),
      .status   (status),
      .mdc_i    (mdc),
      .mdio_i   (mdio_in),
      .mdio_o   (mdio_o),
      .mdio_t   (mdio_t),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   // Master drive value, or the PHY's pad value while the PHY owns the line.
   assign mdio_in = mdio_t ? m_drv : mdio_o;

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_valid) wr_pulses <= wr_pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mdc_bit(input logic b, output logic s, output logic t);
      m_drv = b;
      #40;
      s = mdio_in;
      t = mdio_t;
      mdc = 1'b1;
      #40;
      mdc = 1'b0;
   endtask

   task automatic frame(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input int pre,
                        output logic [15:0] rdata, output int tlow);
      logic        s, t;
      logic [15:0] hdr;
      tlow  = 0;
      rdata = '0;
      for (int i = 0; i < pre; i++) begin
         mdc_bit(1'b1, s, t);
         if (!t) tlow++;
      end
      hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra, (rd ? 2'b11 : 2'b10)};
      for (int i = 15; i >= 0; i--) begin
         mdc_bit(hdr[i], s, t);
         if (!t) tlow++;
      end
      for (int i = 15; i >= 0; i--) begin
         mdc_bit(rd ? 1'b1 : wd[i], s, t);
         if (!t) tlow++;
         rdata = {rdata[14:0], s};
      end
      mdc_bit(1'b1, s, t);
      if (!t) tlow++;
      $display("frame %s pa=%0d ra=%0d wd=%h pre=%0d -> rdata=%h tlow=%0d",
               rd ? "RD" : "WR", pa, ra, wd, pre, rdata, tlow);
   endtask

   initial begin
      logic [15:0] rd;
      int          tl;
      int          wp0;

      repeat (3) @(negedge clk);
      check("rst_mdio_t", mdio_t, 1);
      check("rst_mdio_o", mdio_o, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      wp0 = wr_pulses;
      frame(1'b1, 5'd1, 5'd2, 16'h0, 32, rd, tl);
      check("t1_data", rd, 16'h0022);
      check("t1_tlow", tl, 17);
      check("t1_released", mdio_t, 1);
      check("t1_no_wr", wr_pulses - wp0, 0);

      wp0 = wr_pulses;
      frame(1'b0, 5'd1, 5'd4, 16'hBEEF, 32, rd, tl);
      check("t2_wr_pulse", wr_pulses - wp0, 1);
      check("t2_wr_addr", wr_addr, 4);
      check("t2_wr_data", wr_data, 16'hBEEF);
      check("t2_wr_tlow", tl, 0);
      frame(1'b1, 5'd1, 5'd4, 16'h0, 32, rd, tl);
      check("t2_readback", rd, 16'hBEEF);
      check("t2_tlow", tl, 17);

      wp0 = wr_pulses;
      frame(1'b0, 5'd1, 5'd2, 16'h1234, 32, rd, tl);
      check("t3_wr_pulse", wr_pulses - wp0, 1);
      check("t3_wr_addr", wr_addr, 2);
      check("t3_wr_data", wr_data, 16'h1234);
      frame(1'b1, 5'd1, 5'd2, 16'h0, 32, rd, tl);
      check("t3_ro_readback", rd, 16'h0022);

      wp0 = wr_pulses;
      frame(1'b1, 5'd5, 5'd2, 16'h0, 32, rd, tl);
      check("t4_rd_tlow", tl, 0);
      check("t4_rd_data", rd, 16'hFFFF);
      frame(1'b0, 5'd5, 5'd4, 16'h0000, 32, rd, tl);
      check("t4_no_wr", wr_pulses - wp0, 0);
      frame(1'b1, 5'd1, 5'd4, 16'h0, 32, rd, tl);
      check("t4_reg4_kept", rd, 16'hBEEF);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      frame(1'b1, 5'd1, 5'd3, 16'h0, 31, rd, tl);
      check("t5_short_tlow", tl, 0);
      check("t5_short_data", rd, 16'hFFFF);
      frame(1'b1, 5'd1, 5'd3, 16'h0, 32, rd, tl);
      check("t5_full_data", rd, 16'h1622);
      check("t5_full_tlow", tl, 17);
      frame(1'b1, 5'd1, 5'd4, 16'h0, 32, rd, tl);
      check("t5_reg4_reset", rd, 16'h0000);

      frame(1'b0, 5'd1, 5'd5, 16'hCAFE, 32, rd, tl);
      frame(1'b0, 5'd1, 5'd0, 16'h0100, 32, rd, tl);
      frame(1'b1, 5'd1, 5'd0, 16'h0, 32, rd, tl);
      check("t6_reg0_plain", rd, 16'h0100);
      wp0 = wr_pulses;
      frame(1'b0, 5'd1, 5'd0, 16'h8000, 32, rd, tl);
      check("t6_srst_pulse", wr_pulses - wp0, 1);
      check("t6_srst_wr_data", wr_data, 16'h8000);
      frame(1'b1, 5'd1, 5'd0, 16'h0, 32, rd, tl);
      check("t6_reg0_selfclr", rd, 16'h1140);
      frame(1'b1, 5'd1, 5'd5, 16'h0, 32, rd, tl);
      check("t6_reg5_kept", rd, 16'hCAFE);
      frame(1'b1, 5'd1, 5'd1, 16'h0, 32, rd, tl);
      check("t6_bmsr", rd, BMSR_EXP);
      frame(1'b1, 5'd1, 5'd1, 16'h0, 0, rd, tl);
      check("t6_b2b_data", rd, B2B_DATA);
      check("t6_b2b_tlow", tl, B2B_TLOW);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
